dmem_responder: RTL

- Data-memory responder serving the core's load/store port.
- Accepts one request at a time over a valid/ready handshake and returns the response after a fixed, programmable latency.
- Responses are also valid/ready handshaked.
- Handles RV32I byte, half-word and word accesses (funct3 encoding), little-endian lane steering, load sign/zero extension and misalignment faults.
- Lets the pipeline model see realistic multi-cycle memory instead of combinational readdata.

---
 rtl/dmem_responder.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the core's load/store port: one request at a time,
// fixed programmable latency, RV32I sizes with lane steering, extension and fault detection.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            we_q;
    logic [AW+1:0]   addr_q;
    logic [2:0]      funct3_q;
    logic [31:0]     wdata_q;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;

    logic [31:0]     mem [DEPTH_WORDS];

    logic            accept;
    logic            enter_resp;
    logic            handshake;
    logic            acc_we;
    logic [AW+1:0]   acc_addr;
    logic [2:0]      acc_funct3;
    logic [31:0]     acc_wdata;
    logic [1:0]      lane;
    logic [AW-1:0]   idx;
    logic [31:0]     rd_word;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [31:0]     ld_val;
    logic [31:0]     wr_steer;
    logic [3:0]      be;
    logic            legal;
    logic            write_en;
    logic            unused_addr_bits;

    assign unused_addr_bits = ^req_addr[31:AW+2];

    assign accept     = req_valid && req_ready;
    assign enter_resp = (state_d == RESP) && (state_q != RESP);
    assign handshake  = (state_q == RESP) && resp_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == IDLE) && !reset;
        resp_valid = (state_q == RESP);
    end

    // With LATENCY==1 the access happens on the acceptance edge, so use live inputs then.
    always_comb begin
        if (state_q == IDLE) begin
            acc_we     = req_we;
            acc_addr   = req_addr[AW+1:0];
            acc_funct3 = req_funct3;
            acc_wdata  = req_wdata;
        end else begin
            acc_we     = we_q;
            acc_addr   = addr_q;
            acc_funct3 = funct3_q;
            acc_wdata  = wdata_q;
        end
    end

    always_comb begin
        lane     = acc_addr[1:0];
        idx      = acc_addr[AW+1:2];
        rd_word  = mem[idx];
        byte_sel = rd_word[{lane, 3'b000} +: 8];
        half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];
        legal    = 1'b0;
        be       = 4'b0000;
        ld_val   = 32'h0;
        case (acc_funct3)
            3'b000: begin
                legal  = 1'b1;
                be     = 4'b0001 << lane;
                ld_val = {{24{byte_sel[7]}}, byte_sel};
            end
            3'b001: begin
                legal  = !lane[0];
                be     = 4'b0011 << lane;
                ld_val = {{16{half_sel[15]}}, half_sel};
            end
            3'b010: begin
                legal  = (lane == 2'b00);
                be     = 4'b1111;
                ld_val = rd_word;
            end
            3'b100: begin
                legal  = !acc_we;
                ld_val = {24'h0, byte_sel};
            end
            3'b101: begin
                legal  = !acc_we && !lane[0];
                ld_val = {16'h0, half_sel};
            end
            default: legal = 1'b0;
        endcase

        case (acc_funct3[1:0])
            2'b00:   wr_steer = {4{acc_wdata[7:0]}};
            2'b01:   wr_steer = {2{acc_wdata[15:0]}};
            default: wr_steer = acc_wdata;
        endcase

        rdata_d  = (legal && !acc_we) ? ld_val : 32'h0;
        err_d    = !legal;
        write_en = enter_resp && acc_we && legal && !reset;
    end

    // Storage is not reset; only the enabled byte lanes are updated.
    always_ff @(posedge clk) begin
        if (write_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][b*8 +: 8] <= wr_steer[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we_q     <= 1'b0;
            addr_q   <= '0;
            funct3_q <= 3'b000;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                we_q     <= req_we;
                addr_q   <= req_addr[AW+1:0];
                funct3_q <= req_funct3;
                wdata_q  <= req_wdata;
            end
            if (enter_resp) begin
                rdata_q <= rdata_d;
                err_q   <= err_d;
            end else if (handshake) begin
                rdata_q <= 32'h0;
                err_q   <= 1'b0;
            end
        end
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule
